// File: rtl/i2c_xfer_seq_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
package i2c_xfer_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R, ST_RDATA, ST_FINISH
  } state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Host command/buffer port plus byte-engine frame port of the sequencer.
interface i2c_xfer_seq_if #(
  parameter int AW    = 4,
  parameter int LEN_W = 5
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rnw;
  logic [6:0]       cmd_dev;
  logic [7:0]       cmd_reg;
  logic [LEN_W-1:0] cmd_len;
  logic             buf_we;
  logic [AW-1:0]    buf_addr;
  logic [7:0]       buf_wdata;
  logic [7:0]       buf_rdata;
  logic             busy;
  logic             done;
  logic             nack_err;
  logic             eng_nreset;
  logic [7:0]       eng_wbyte;
  logic             eng_rmode;
  logic             eng_start;
  logic             eng_stop;
  logic             eng_finished;
  logic             eng_ack;
  logic [7:0]       eng_rbyte;

  // master = host plus byte engine; slave = sequencer
  modport master (
    output cmd_valid, cmd_rnw, cmd_dev, cmd_reg, cmd_len,
    output buf_we, buf_addr, buf_wdata,
    output eng_finished, eng_ack, eng_rbyte,
    input  cmd_ready, buf_rdata, busy, done, nack_err,
    input  eng_nreset, eng_wbyte, eng_rmode, eng_start, eng_stop
  );
  modport slave (
    input  cmd_valid, cmd_rnw, cmd_dev, cmd_reg, cmd_len,
    input  buf_we, buf_addr, buf_wdata,
    input  eng_finished, eng_ack, eng_rbyte,
    output cmd_ready, buf_rdata, busy, done, nack_err,
    output eng_nreset, eng_wbyte, eng_rmode, eng_start, eng_stop
  );
endinterface

// File: rtl/i2c_byte_buf.sv
// DEPTH x 8 payload buffer: one write port, two registered read ports (host, sequencer).
module i2c_byte_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_a_q, rdata_b_q;

  // reads see the pre-write contents on a same-cycle collision
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;
endmodule

// File: rtl/i2c_xfer_seq.sv
// Expands one host register-access command into byte-engine frames; engine held in reset when idle.
module i2c_xfer_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LEN_W = 5
) (
  input logic           clock,
  input logic           nreset,
  i2c_xfer_seq_if.slave bus
);
  import i2c_xfer_seq_pkg::*;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_e           state_q, state_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             nack_q, nack_d;
  logic             seq_we, nack_in, last_byte;
  logic [LEN_W-1:0] len_sat;
  logic [7:0]       seq_rdata;
  logic [7:0]       wbyte;
  logic             rmode, start, stop;

  assign len_sat   = (bus.cmd_len > DEPTH_L) ? DEPTH_L : bus.cmd_len;
  assign last_byte = (LEN_W'(idx_q) == len_q - 1'b1);
  assign nack_in   = bus.eng_finished && (bus.eng_ack == I2C_NACK);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      rnw_q   <= I2C_RW_WRITE;
      dev_q   <= '0;
      reg_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    len_d   = len_q;
    idx_d   = idx_q;
    nack_d  = nack_q;
    seq_we  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cmd_valid) begin
        state_d = ST_ADDR_W;
        rnw_d   = bus.cmd_rnw;
        dev_d   = bus.cmd_dev;
        reg_d   = bus.cmd_reg;
        len_d   = len_sat;
        idx_d   = '0;
        nack_d  = 1'b0;
      end
      ST_ADDR_W: if (bus.eng_finished) state_d = ST_REG;
      ST_REG: if (bus.eng_finished) begin
        idx_d = '0;
        if (len_q == '0)                state_d = ST_FINISH;
        else if (rnw_q == I2C_RW_READ)  state_d = ST_ADDR_R;
        else                            state_d = ST_WDATA;
      end
      ST_WDATA: if (bus.eng_finished) begin
        if (last_byte) state_d = ST_FINISH;
        else           idx_d   = idx_q + 1'b1;
      end
      ST_ADDR_R: if (bus.eng_finished) begin
        state_d = ST_RDATA;
        idx_d   = '0;
      end
      ST_RDATA: if (bus.eng_finished) begin
        seq_we = 1'b1;
        if (last_byte) state_d = ST_FINISH;
        else           idx_d   = idx_q + 1'b1;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    // read-data frames carry no slave ACK, so only address/write frames can abort
    if (nack_in && (state_q inside {ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R})) begin
      state_d = ST_FINISH;
      nack_d  = 1'b1;
    end
  end

  always_comb begin
    wbyte = '0;
    rmode = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    case (state_q)
      ST_ADDR_W: begin wbyte = {dev_q, I2C_RW_WRITE}; start = 1'b1; end
      ST_REG:    begin wbyte = reg_q; stop = (len_q == '0); end
      ST_WDATA:  begin wbyte = seq_rdata; stop = last_byte; end
      ST_ADDR_R: begin wbyte = {dev_q, I2C_RW_READ}; start = 1'b1; end
      ST_RDATA:  begin rmode = 1'b1; stop = last_byte; end
      default:   ;
    endcase
  end

  // sequencer read port tracks idx_d so buf[idx] is ready the cycle a WDATA frame starts
  i2c_byte_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clock     (clock),
    .we_i      (seq_we || (bus.buf_we && state_q == ST_IDLE)),
    .waddr_i   (seq_we ? idx_q : bus.buf_addr),
    .wdata_i   (seq_we ? bus.eng_rbyte : bus.buf_wdata),
    .raddr_a_i (bus.buf_addr),
    .rdata_a_o (bus.buf_rdata),
    .raddr_b_i (idx_d),
    .rdata_b_o (seq_rdata)
  );

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.nack_err   = nack_q;
  assign bus.eng_nreset = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign bus.eng_wbyte  = wbyte;
  assign bus.eng_rmode  = rmode;
  assign bus.eng_start  = start;
  assign bus.eng_stop   = stop;
endmodule
